// File: rtl/triangle_span_scheduler_if.sv
// Bundle of all handshake and data signals of triangle_span_scheduler.
// Ports: triangle in (v*, tri_*), walker A/B (ea_*, eb_*), span out (span_*).
// master: the scheduler's view; slave: the surrounding environment's view.
interface triangle_span_scheduler_if;
    logic [8:0] v0x, v0y, v1x, v1y, v2x, v2y;
    logic       tri_valid, tri_ready, tri_done;

    logic [8:0] ea_x1, ea_y1, ea_x2, ea_y2;
    logic       ea_start, ea_ack;
    logic [8:0] ea_x, ea_y;
    logic       ea_valid, ea_done;

    logic [8:0] eb_x1, eb_y1, eb_x2, eb_y2;
    logic       eb_start, eb_ack;
    logic [8:0] eb_x, eb_y;
    logic       eb_valid, eb_done;

    logic [8:0] span_y, span_xl, span_xr;
    logic       span_valid, span_ready;

    modport master (
        input  v0x, v0y, v1x, v1y, v2x, v2y, tri_valid,
        output tri_ready, tri_done,
        output ea_x1, ea_y1, ea_x2, ea_y2, ea_start, ea_ack,
        input  ea_x, ea_y, ea_valid, ea_done,
        output eb_x1, eb_y1, eb_x2, eb_y2, eb_start, eb_ack,
        input  eb_x, eb_y, eb_valid, eb_done,
        output span_y, span_xl, span_xr, span_valid,
        input  span_ready
    );

    modport slave (
        output v0x, v0y, v1x, v1y, v2x, v2y, tri_valid,
        input  tri_ready, tri_done,
        input  ea_x1, ea_y1, ea_x2, ea_y2, ea_start, ea_ack,
        output ea_x, ea_y, ea_valid, ea_done,
        input  eb_x1, eb_y1, eb_x2, eb_y2, eb_start, eb_ack,
        output eb_x, eb_y, eb_valid, eb_done,
        input  span_y, span_xl, span_xr, span_valid,
        output span_ready
    );
endinterface

// File: rtl/triangle_span_scheduler.sv
// Triangle span scheduler: sorts three vertices by y, walks the long edge
// with walker A and the two short edges with walker B, and pairs their
// per-scanline points into inclusive spans (span_y, span_xl, span_xr).
// Ports: clk, reset_n (async, active low), bus (master modport):
//   triangle valid/ready in, tri_done pulse, walker A/B endpoints,
//   start/ack pulses and point inputs, span valid/ready out.
// Optional: define SPAN_CLIP_EN to drop spans with xl > XMAX and clamp
//   xr to XMAX; otherwise spans pass unmodified.
module triangle_span_scheduler #(
    parameter int XMAX = 319
) (
    input  logic                      clk,
    input  logic                      reset_n,
    triangle_span_scheduler_if.master bus
);

`ifdef SPAN_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    localparam logic [8:0] XLIM = 9'(XMAX);

    typedef enum logic [2:0] {
        IDLE,
        SORT,
        START,
        PAIR,
        EMIT,
        DRAIN
    } state_t;

    state_t     state;
    logic       seg;
    logic       ack_d;
    logic [8:0] lx0, ly0, lx1, ly1, lx2, ly2;
    logic [8:0] mid_x, mid_y, bot_x, bot_y;

    logic [1:0] r0, r1, r2;
    logic [8:0] tx, ty, mx, my, bx, by;

    logic       sample_ok;
    logic       pair_hit;
    logic       drop;
    logic [8:0] xl, xr, xr_c;

    // Rank = number of vertices ordered before this one; ties resolve
    // in favour of the lower input index, so the ranks form a permutation.
    always_comb begin
        r0 = 2'(ly1 < ly0) + 2'(ly2 < ly0);
        r1 = 2'(ly0 <= ly1) + 2'(ly2 < ly1);
        r2 = 2'(ly0 <= ly2) + 2'(ly1 <= ly2);
    end

    always_comb begin
        tx = lx0;
        ty = ly0;
        unique case (1'b1)
            r1 == 2'd0: begin tx = lx1; ty = ly1; end
            r2 == 2'd0: begin tx = lx2; ty = ly2; end
            default: ;
        endcase
    end

    always_comb begin
        mx = lx0;
        my = ly0;
        unique case (1'b1)
            r1 == 2'd1: begin mx = lx1; my = ly1; end
            r2 == 2'd1: begin mx = lx2; my = ly2; end
            default: ;
        endcase
    end

    always_comb begin
        bx = lx0;
        by = ly0;
        unique case (1'b1)
            r1 == 2'd2: begin bx = lx1; by = ly1; end
            r2 == 2'd2: begin bx = lx2; by = ly2; end
            default: ;
        endcase
    end

    // Walker valid/done lag a start or ack by one edge, so they are ignored
    // while a pulse is out and in the cycle after an ack.
    always_comb begin
        sample_ok = ~(bus.ea_start | bus.eb_start |
                      bus.ea_ack | bus.eb_ack | ack_d);
        pair_hit  = sample_ok & bus.ea_valid & bus.eb_valid;
        xl        = (bus.ea_x < bus.eb_x) ? bus.ea_x : bus.eb_x;
        xr        = (bus.ea_x < bus.eb_x) ? bus.eb_x : bus.ea_x;
        drop      = CLIP & (xl > XLIM);
        xr_c      = (CLIP && (xr > XLIM)) ? XLIM : xr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            seg            <= 1'b0;
            ack_d          <= 1'b0;
            lx0            <= '0;
            ly0            <= '0;
            lx1            <= '0;
            ly1            <= '0;
            lx2            <= '0;
            ly2            <= '0;
            mid_x          <= '0;
            mid_y          <= '0;
            bot_x          <= '0;
            bot_y          <= '0;
            bus.tri_ready  <= 1'b0;
            bus.tri_done   <= 1'b0;
            bus.ea_start   <= 1'b0;
            bus.eb_start   <= 1'b0;
            bus.ea_ack     <= 1'b0;
            bus.eb_ack     <= 1'b0;
            bus.ea_x1      <= '0;
            bus.ea_y1      <= '0;
            bus.ea_x2      <= '0;
            bus.ea_y2      <= '0;
            bus.eb_x1      <= '0;
            bus.eb_y1      <= '0;
            bus.eb_x2      <= '0;
            bus.eb_y2      <= '0;
            bus.span_valid <= 1'b0;
            bus.span_y     <= '0;
            bus.span_xl    <= '0;
            bus.span_xr    <= '0;
        end else begin
            bus.tri_done <= 1'b0;
            bus.ea_start <= 1'b0;
            bus.eb_start <= 1'b0;
            bus.ea_ack   <= 1'b0;
            bus.eb_ack   <= 1'b0;
            ack_d        <= bus.ea_ack | bus.eb_ack;

            case (state)
                IDLE: begin
                    bus.tri_ready <= 1'b1;
                    if (bus.tri_valid && bus.tri_ready) begin
                        lx0           <= bus.v0x;
                        ly0           <= bus.v0y;
                        lx1           <= bus.v1x;
                        ly1           <= bus.v1y;
                        lx2           <= bus.v2x;
                        ly2           <= bus.v2y;
                        bus.tri_ready <= 1'b0;
                        state         <= SORT;
                    end
                end

                SORT: begin
                    mid_x        <= mx;
                    mid_y        <= my;
                    bot_x        <= bx;
                    bot_y        <= by;
                    bus.ea_x1    <= tx;
                    bus.ea_y1    <= ty;
                    bus.ea_x2    <= bx;
                    bus.ea_y2    <= by;
                    bus.eb_x1    <= tx;
                    bus.eb_y1    <= ty;
                    bus.eb_x2    <= mx;
                    bus.eb_y2    <= my;
                    bus.ea_start <= 1'b1;
                    bus.eb_start <= 1'b1;
                    state        <= START;
                end

                START: begin
                    seg   <= 1'b0;
                    state <= PAIR;
                end

                PAIR: begin
                    if (pair_hit) begin
                        if (drop) begin
                            bus.ea_ack <= 1'b1;
                            bus.eb_ack <= 1'b1;
                        end else begin
                            bus.span_y     <= bus.ea_y;
                            bus.span_xl    <= xl;
                            bus.span_xr    <= xr_c;
                            bus.span_valid <= 1'b1;
                            state          <= EMIT;
                        end
                    end else if (sample_ok && bus.eb_done) begin
                        if (!seg) begin
                            // Second short edge; A keeps its point pending.
                            bus.eb_x1    <= mid_x;
                            bus.eb_y1    <= mid_y;
                            bus.eb_x2    <= bot_x;
                            bus.eb_y2    <= bot_y;
                            bus.eb_start <= 1'b1;
                            seg          <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end

                EMIT: begin
                    if (bus.span_ready) begin
                        bus.span_valid <= 1'b0;
                        bus.ea_ack     <= 1'b1;
                        bus.eb_ack     <= 1'b1;
                        state          <= PAIR;
                    end
                end

                DRAIN: begin
                    if (bus.ea_done) begin
                        bus.tri_done  <= 1'b1;
                        bus.tri_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
